serial_addsub_ctrl: RTL and testbench

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/alu_pkg.sv | 13 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_addsub_ctrl.sv | 110 +++++++++++
 tb/tb_serial_addsub_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract controller: FSM state
// encodings and the default operand width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell used for the bit-serial datapath.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor. One operand bit pair is added per RUN cycle,
// LSB first, through a single full adder. Subtraction is a + ~b + 1, with the
// +1 injected as the initial carry. Flags are captured on the last bit.
module serial_addsub_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             msb_cin;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] next_result;

  full_adder_1bit u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign next_result = {fa_sum, result[WIDTH-1:1]};

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  assign overflow = msb_cin ^ cout;

  // Operand shift registers: loaded on an accepted start, shifted right per bit.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_a <= a;
      op_b <= sub ? ~b : b;
    end else if (state == RUN) begin
      op_a <= op_a >> 1;
      op_b <= op_b >> 1;
    end
  end

  // Control FSM, bit counter, carry chain, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      carry   <= 1'b0;
      msb_cin <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result <= next_result;
          carry  <= fa_cout;
          if (cnt == LAST) begin
            cout    <= fa_cout;
            msb_cin <= carry;
            zero    <= (next_result == '0);
            done    <= 1'b1;
            state   <= FINISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=32.
module tb_serial_addsub_ctrl;

  localparam int W       = 32;
  localparam int LAT     = W + 1;
  localparam int TIMEOUT = 100;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         zero;

  int total;
  int bad;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and return the cycle count (start cycle = 0) at which
  // done is first seen; TIMEOUT is returned if done never rises.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic isub, output int lat);
    int n;
    @(posedge clk); #1;
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero got=%0b want=1", zero); end
    total++; if (cout !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got cout=%0b ov=%0b want 0 0", cout, overflow);
    end
    // rst and start together: rst must win
    start = 1'b1; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_over_start got busy=%0b want=0", busy); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset got busy=%0b want=0", busy); end
  endtask

  task automatic test_add();
    int lat;
    logic [W-1:0] held;
    run_op(32'd3, 32'd4, 1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL add_latency got=%0d want=%0d", lat, LAT); end
    total++; if (result !== 32'd7) begin bad++; $display("FAIL add_result got=%h want=7", result); end
    total++; if (cout !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      bad++; $display("FAIL add_flags got c=%0b v=%0b z=%0b want 0 0 0", cout, overflow, zero);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_finish got=%0b want=1", busy); end
    held = result;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL add_pulse got done=%0b busy=%0b want 0 0", done, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (result !== held || zero !== 1'b0) begin
      bad++; $display("FAIL add_hold got=%h z=%0b want=%h z=0", result, zero, held);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL ovf_latency got=%0d want=%0d", lat, LAT); end
    total++; if (result !== 32'h8000_0000 || overflow !== 1'b1 || cout !== 1'b0) begin
      bad++; $display("FAIL ovf_add got=%h v=%0b c=%0b want=80000000 v=1 c=0", result, overflow, cout);
    end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    total++; if (result !== 32'h0 || cout !== 1'b1 || overflow !== 1'b0 || zero !== 1'b1) begin
      bad++; $display("FAIL wrap_add got=%h c=%0b v=%0b z=%0b want=0 c=1 v=0 z=1", result, cout, overflow, zero);
    end
    run_op(32'h8000_0000, 32'd1, 1'b1, lat);
    total++; if (result !== 32'h7FFF_FFFF || cout !== 1'b1 || overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_sub got=%h c=%0b v=%0b want=7fffffff c=1 v=1", result, cout, overflow);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(32'd5, 32'd5, 1'b1, lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL sub_latency got=%0d want=%0d", lat, LAT); end
    total++; if (result !== 32'h0 || zero !== 1'b1 || cout !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL sub_equal got=%h z=%0b c=%0b v=%0b want=0 z=1 c=1 v=0", result, zero, cout, overflow);
    end
    run_op(32'd0, 32'd1, 1'b1, lat);
    total++; if (result !== 32'hFFFF_FFFF || cout !== 1'b0 || zero !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL sub_borrow got=%h c=%0b z=%0b v=%0b want=ffffffff c=0 z=0 v=0", result, cout, zero, overflow);
    end
  endtask

  task automatic test_start_ignored();
    int n;
    int dones;
    int lat;
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; dones = 0; lat = TIMEOUT;
    while (n < TIMEOUT && lat == TIMEOUT) begin
      if (n == 10) begin
        a = 32'd100; b = 32'd200; sub = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (done) begin dones++; lat = n; end
    end
    total++; if (lat !== LAT) begin bad++; $display("FAIL restart_latency got=%0d want=%0d", lat, LAT); end
    total++; if (result !== 32'h2345_6789) begin
      bad++; $display("FAIL restart_result got=%h want=23456789", result);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", dones); end
  endtask

  task automatic test_rst_abort();
    int n;
    int dones;
    int lat;
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 15) begin
      @(posedge clk); #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl got busy=%0b done=%0b want 0 0", busy, done);
    end
    total++; if (result !== '0 || zero !== 1'b1) begin
      bad++; $display("FAIL abort_result got=%h z=%0b want=0 z=1", result, zero);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    run_op(32'd10, 32'd20, 1'b0, lat);
    total++; if (lat !== LAT || result !== 32'd30) begin
      bad++; $display("FAIL after_abort got lat=%0d res=%h want lat=%0d res=1e", lat, result, LAT);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_start_ignored();
    test_rst_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
